// File: rtl/matrix_catalog_reporter.sv
// Scans matrix storage over every (row,col) size, prints "RxC:N\n" per non-empty size
// and a "=T\n" summary over UART, and picks one non-empty size by ordinal from rand_val.
module matrix_catalog_reporter #(
  parameter int MAX_ROW    = 5,
  parameter int MAX_COL    = 5,
  parameter int CNT_W      = 5,
  parameter int CNT_DIGITS = 2,
  parameter int TOT_W      = 10,
  parameter int TOT_DIGITS = 4,
  parameter int RD_LAT     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       rand_val,
  output logic             busy,
  output logic             done,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [2:0]       qry_row,
  output logic [2:0]       qry_col,
  input  logic [CNT_W-1:0] qry_cnt,
  output logic [7:0]       type_count,
  output logic [TOT_W-1:0] total_count,
  output logic             sel_valid,
  output logic [2:0]       sel_row,
  output logic [2:0]       sel_col,
  output logic [CNT_W-1:0] sel_cnt
);

  typedef enum logic [3:0] {
    IDLE, CNT_ADDR, CNT_WAIT, CNT_READ, MOD, PR_ADDR, PR_WAIT, PR_READ,
    SUM_SETUP, GEN, DIG, TX_START, TX_WAIT_HI, TX_WAIT_LO, DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_ROW, PH_X, PH_COL, PH_COLON, PH_EQ, PH_NUM, PH_LF, PH_END
  } phase_t;

  localparam int WW = $clog2(RD_LAT + 1);
  localparam logic [WW-1:0] LAT_M1 = WW'(RD_LAT - 1);

  state_t state, next_state;
  phase_t phase;

  logic             start_q, start_edge, in_sum, last, started, ge, emit;
  logic [2:0]       row, col, nrow, ncol;
  logic [WW-1:0]    wcnt;
  logic [7:0]       tgt, ord, byte_q;
  logic [TOT_W-1:0] num, pw;
  logic [3:0]       k, dig;

  function automatic logic [TOT_W-1:0] pow10(input logic [3:0] e);
    logic [TOT_W-1:0] p;
    p = TOT_W'(1);
    for (int unsigned i = 0; i < 15; i++)
      if (i < 32'(e)) p = p * TOT_W'(10);
    return p;
  endfunction

  assign start_edge = start & ~start_q;
  assign last       = (row == 3'(MAX_ROW)) && (col == 3'(MAX_COL));
  assign ncol       = (col == 3'(MAX_COL)) ? 3'd1 : col + 3'd1;
  assign nrow       = (col == 3'(MAX_COL)) ? row + 3'd1 : row;
  assign pw         = pow10(k);
  assign ge         = num >= pw;
  // a digit is sent once it is non-zero, follows a sent digit, or is the units digit
  assign emit       = !ge && ((dig != 4'd0) || started || (k == 4'd0));

  assign tx_data = byte_q;
  assign qry_row = row;
  assign qry_col = col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort && state != IDLE) next_state = IDLE;
    else begin
      case (state)
        IDLE:       if (start_edge) next_state = CNT_ADDR;
        CNT_ADDR:   next_state = (RD_LAT == 1) ? CNT_READ : CNT_WAIT;
        CNT_WAIT:   if (wcnt >= LAT_M1) next_state = CNT_READ;
        CNT_READ:   next_state = last ? MOD : CNT_ADDR;
        MOD: begin
          if (type_count == 8'd0)    next_state = SUM_SETUP;
          else if (tgt < type_count) next_state = PR_ADDR;
        end
        PR_ADDR:    next_state = (RD_LAT == 1) ? PR_READ : PR_WAIT;
        PR_WAIT:    if (wcnt >= LAT_M1) next_state = PR_READ;
        PR_READ: begin
          if (qry_cnt != '0) next_state = GEN;
          else               next_state = last ? SUM_SETUP : PR_ADDR;
        end
        SUM_SETUP:  next_state = GEN;
        GEN: begin
          case (phase)
            PH_NUM:  next_state = DIG;
            PH_END:  next_state = in_sum ? DONE : (last ? SUM_SETUP : PR_ADDR);
            default: next_state = TX_START;
          endcase
        end
        DIG:        if (emit) next_state = TX_START;
        TX_START:   next_state = TX_WAIT_HI;
        TX_WAIT_HI: if (tx_busy) next_state = TX_WAIT_LO;
        TX_WAIT_LO: if (!tx_busy) next_state = GEN;
        DONE:       next_state = IDLE;
        default:    next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE) && (state != DONE);
    done     = (state == DONE);
    tx_start = (state == TX_START) || (state == TX_WAIT_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= 1'b1;
      row         <= 3'd1;
      col         <= 3'd1;
      wcnt        <= '0;
      tgt         <= '0;
      ord         <= '0;
      num         <= '0;
      k           <= '0;
      dig         <= '0;
      started     <= 1'b0;
      in_sum      <= 1'b0;
      phase       <= PH_ROW;
      byte_q      <= '0;
      type_count  <= '0;
      total_count <= '0;
      sel_valid   <= 1'b0;
      sel_row     <= '0;
      sel_col     <= '0;
      sel_cnt     <= '0;
    end else begin
      start_q <= start;
      if (abort && state != IDLE) sel_valid <= 1'b0;
      else begin
        case (state)
          IDLE: if (start_edge && !abort) begin
            sel_valid   <= 1'b0;
            tgt         <= rand_val;
            type_count  <= '0;
            total_count <= '0;
            ord         <= '0;
            row         <= 3'd1;
            col         <= 3'd1;
          end
          CNT_ADDR, PR_ADDR: wcnt <= WW'(1);
          CNT_WAIT, PR_WAIT: wcnt <= wcnt + WW'(1);
          CNT_READ: begin
            if (qry_cnt != '0) begin
              type_count  <= type_count + 8'd1;
              total_count <= total_count + TOT_W'(qry_cnt);
            end
            if (!last) begin
              row <= nrow;
              col <= ncol;
            end
          end
          MOD: if (type_count != 8'd0) begin
            if (tgt >= type_count) tgt <= tgt - type_count;
            else begin
              row <= 3'd1;
              col <= 3'd1;
            end
          end
          PR_READ: begin
            if (qry_cnt != '0) begin
              num    <= TOT_W'(qry_cnt);
              phase  <= PH_ROW;
              in_sum <= 1'b0;
              ord    <= ord + 8'd1;
              if (ord == tgt) begin
                sel_row <= row;
                sel_col <= col;
                sel_cnt <= qry_cnt;
              end
            end else if (!last) begin
              row <= nrow;
              col <= ncol;
            end
          end
          SUM_SETUP: begin
            num    <= total_count;
            phase  <= PH_EQ;
            in_sum <= 1'b1;
          end
          GEN: begin
            case (phase)
              PH_ROW:   begin byte_q <= 8'h30 + {5'd0, row}; phase <= PH_X; end
              PH_X:     begin byte_q <= 8'h78; phase <= PH_COL; end
              PH_COL:   begin byte_q <= 8'h30 + {5'd0, col}; phase <= PH_COLON; end
              PH_COLON: begin
                byte_q  <= 8'h3A;
                phase   <= PH_NUM;
                k       <= 4'(CNT_DIGITS - 1);
                dig     <= '0;
                started <= 1'b0;
              end
              PH_EQ: begin
                byte_q  <= 8'h3D;
                phase   <= PH_NUM;
                k       <= 4'(TOT_DIGITS - 1);
                dig     <= '0;
                started <= 1'b0;
              end
              PH_LF:    begin byte_q <= 8'h0A; phase <= PH_END; end
              PH_END: if (!in_sum && !last) begin
                row <= nrow;
                col <= ncol;
              end
              PH_NUM:   ;
            endcase
          end
          DIG: begin
            if (ge) begin
              num <= num - pw;
              dig <= dig + 4'd1;
            end else begin
              dig <= '0;
              if (k != 4'd0) k <= k - 4'd1;
              if (emit) begin
                byte_q  <= 8'h30 + {4'd0, dig};
                started <= 1'b1;
                if (k == 4'd0) phase <= PH_LF;
              end
            end
          end
          DONE: sel_valid <= (type_count != 8'd0);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_catalog_reporter.sv
// Directed bench for matrix_catalog_reporter: storage model with 2-cycle read latency
// and a uart_tx model with configurable busy delay/length that logs every byte.
module tb_matrix_catalog_reporter;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, tx_busy;
  logic [7:0] rand_val;
  logic [4:0] qry_cnt;
  logic       busy, done, tx_start, sel_valid;
  logic [7:0] tx_data, type_count;
  logic [2:0] qry_row, qry_col, sel_row, sel_col;
  logic [9:0] total_count;
  logic [4:0] sel_cnt;

  int    total = 0, bad = 0;
  int    done_cnt = 0, stab_err = 0;
  int    hi_dly = 1, busy_len = 2;
  string rx_str = "";
  logic [7:0] cur;
  logic [4:0] mem [0:7][0:7];
  logic [4:0] s1;

  always #5 clk = ~clk;

  matrix_catalog_reporter #(
    .MAX_ROW(5), .MAX_COL(5), .CNT_W(5), .CNT_DIGITS(2),
    .TOT_W(10), .TOT_DIGITS(4), .RD_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rand_val(rand_val),
    .busy(busy), .done(done), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .qry_row(qry_row), .qry_col(qry_col), .qry_cnt(qry_cnt),
    .type_count(type_count), .total_count(total_count),
    .sel_valid(sel_valid), .sel_row(sel_row), .sel_col(sel_col), .sel_cnt(sel_cnt)
  );

  // storage: two register stages between address and count
  always @(posedge clk) begin
    s1      <= mem[qry_row][qry_col];
    qry_cnt <= s1;
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  end

  // uart_tx model
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !tx_busy) begin
        cur = tx_data;
        if (cur == 8'h0A) rx_str = {rx_str, "\\n"};
        else              rx_str = {rx_str, $sformatf("%c", cur)};
        repeat (hi_dly - 1) begin
          @(negedge clk);
          if (tx_data !== cur) stab_err++;
        end
        tx_busy = 1'b1;
        repeat (busy_len) begin
          @(negedge clk);
          if (tx_data !== cur) stab_err++;
        end
        tx_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: observed=\"%s\" expected=\"%s\"", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mem[r][c] = 5'd0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clk);
    chk(tag, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic wait_uart_idle();
    for (int i = 0; i < 200 && tx_busy; i++) @(negedge clk);
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] rv, input string exp);
    int d0;
    d0 = done_cnt;
    rx_str = "";
    stab_err = 0;
    @(negedge clk);
    rand_val = rv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_run"}, 32'(busy), 32'd1);
    wait_done({tag, "_done_seen"}, d0);
    repeat (2) @(negedge clk);
    chk_str({tag, "_stream"}, rx_str, exp);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_tx_stable"}, 32'(stab_err), 32'd0);
  endtask

  initial begin
    int d0;
    bit found;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rand_val = 8'd0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_qry_row", 32'(qry_row), 32'd1);
    chk("rst_qry_col", 32'(qry_col), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_type_count", 32'(type_count), 32'd0);
    chk("rst_total", 32'(total_count), 32'd0);
    chk("rst_sel_valid", 32'(sel_valid), 32'd0);
    chk("rst_sel_cnt", 32'(sel_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // two non-empty sizes, rand 7 mod 2 = 1 selects the second
    mem[2][3] = 5'd4; mem[5][5] = 5'd12;
    run_and_check("t1", 8'd7, "2x3:4\\n5x5:12\\n=16\\n");
    chk("t1_type_count", 32'(type_count), 32'd2);
    chk("t1_total", 32'(total_count), 32'd16);
    chk("t1_sel_row", 32'(sel_row), 32'd5);
    chk("t1_sel_col", 32'(sel_col), 32'd5);
    chk("t1_sel_cnt", 32'(sel_cnt), 32'd12);
    chk("t1_sel_valid", 32'(sel_valid), 32'd1);

    clear_mem();
    run_and_check("t2", 8'd200, "=0\\n");
    chk("t2_type_count", 32'(type_count), 32'd0);
    chk("t2_total", 32'(total_count), 32'd0);
    chk("t2_sel_valid", 32'(sel_valid), 32'd0);

    mem[1][1] = 5'd31;
    run_and_check("t3", 8'd0, "1x1:31\\n=31\\n");
    chk("t3_sel_row", 32'(sel_row), 32'd1);
    chk("t3_sel_col", 32'(sel_col), 32'd1);
    chk("t3_sel_cnt", 32'(sel_cnt), 32'd31);
    chk("t3_sel_valid", 32'(sel_valid), 32'd1);
    chk("t3_total", 32'(total_count), 32'd31);

    // slow uart: busy rises late and stays long
    clear_mem();
    mem[2][3] = 5'd4; mem[5][5] = 5'd12;
    hi_dly = 3; busy_len = 20;
    run_and_check("t4", 8'd7, "2x3:4\\n5x5:12\\n=16\\n");
    chk("t4_sel_row", 32'(sel_row), 32'd5);
    hi_dly = 1; busy_len = 2;

    // abort while ':' of the first line is being requested
    d0 = done_cnt;
    rx_str = "";
    @(negedge clk);
    rand_val = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1 && tx_data === 8'h3A) found = 1'b1;
    end
    chk("t5_colon_seen", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy_after_abort", 32'(busy), 32'd0);
    chk("t5_tx_start_after_abort", 32'(tx_start), 32'd0);
    chk("t5_sel_valid_after_abort", 32'(sel_valid), 32'd0);
    repeat (100) @(negedge clk);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_still_idle", 32'(busy), 32'd0);
    wait_uart_idle();
    repeat (2) @(negedge clk);
    run_and_check("t5_rerun", 8'd7, "2x3:4\\n5x5:12\\n=16\\n");

    // start held high through reset, then extra start pulses during the run
    start = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    chk("t6_no_run_after_reset", 32'(busy), 32'd0);
    start = 1'b0;
    rx_str = "";
    stab_err = 0;
    @(negedge clk);
    rand_val = 8'd7; start = 1'b1;
    @(negedge clk);
    chk("t6_run_started", 32'(busy), 32'd1);
    repeat (30) @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6_done_seen", d0);
    repeat (400) @(negedge clk);
    chk_str("t6_stream", rx_str, "2x3:4\\n5x5:12\\n=16\\n");
    chk("t6_single_run", 32'(done_cnt - d0), 32'd1);
    chk("t6_idle_after", 32'(busy), 32'd0);
    chk("t6_sel_cnt", 32'(sel_cnt), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
